axi_llc_r_resp_buf: RTL and testbench
=====================================

// Module: axi_llc_r_resp_buf
// PURPOSE
// Credit-controlled response buffer between the data-way output mux (read-unit response) and the AXI R channel.
// Stores each way read response and emits it in order as an R beat.
// Issues credits back to the read unit so that no way request is made unless a buffer slot is reserved.
// Because of that, a way response is never back-pressured.
// PARAMETERS
// DataWidth  64  R data width in bits (= LLC block/beat width)
// IdWidth    6   AXI ID width
// Depth      4   buffer entries = max reserved (outstanding + stored) responses; legal range >= 2
// PORTS
// clk_i         in   1                  clock, rising edge
// rst_ni        in   1                  asynchronous reset, active low
// req_grant_i   in   1                  read-unit way request handshaked this cycle (reserves one slot)
// can_issue_o   out  1                  a slot is free; read unit may handshake a way request
// way_valid_i   in   1                  way response valid
// way_ready_o   out  1                  buffer accepts way response
// way_data_i    in   DataWidth          response data
// way_id_i      in   IdWidth            response AXI ID
// way_last_i    in   1                  last beat of burst
// r_valid_o     out  1                  R beat valid
// r_ready_i     in   1                  R beat accepted
// r_data_o      out  DataWidth          R data
// r_id_o        out  IdWidth            R ID
// r_last_o      out  1                  R last
// r_resp_o      out  2                  R resp, constant 2'b00 (OKAY)
// usage_o       out  $clog2(Depth+1)    entries stored (not reserved)
// BEHAVIOUR
// - Reset (async, rst_ni=0): all pointers and counters are cleared; can_issue_o=1, way_ready_o=1, r_valid_o=0,
//   usage_o=0, and r_data_o/r_id_o/r_last_o=0. Reset mid-operation discards all stored and reserved entries.
// - Storage: circular FIFO, Depth entries {data,id,last}, write/read pointers wrap at Depth (Depth need not be 2^n).
// - Latency: a way response accepted in cycle N is presented on R in cycle N+1 at the earliest (no fall-through).
//   R outputs come from the head entry; order is strictly FIFO.
// - reserved counter, width $clog2(Depth+1): +1 on req_grant_i, -1 on R handshake (r_valid_o & r_ready_i).
//   If both occur in the same cycle, the counter is unchanged.
// - can_issue_o = (reserved < Depth), combinational from the register. The read unit gates its way-request
//   valid with can_issue_o, so req_grant_i while reserved==Depth is illegal (assertion).
// - way_ready_o = (usage_o < Depth). It is always 1 under legal use; way_valid_i & !way_ready_o fires an assertion.
// - usage_o: +1 on way handshake, -1 on R handshake; if both occur in the same cycle it is unchanged.
//   Empty: r_valid_o=0. Full: way_ready_o=0.
// - Simultaneous push and pop when full is not possible because way_ready_o=0. Push and pop when
//   usage_o==1: the head is popped and the new entry becomes the head the next cycle.
// - AXI rules: once r_valid_o=1 it stays 1, and r_data/id/last stay stable, until r_ready_i=1.
// - Invariants (assertions): usage_o <= reserved <= Depth; way response while usage_o==reserved is an error
//   (a response arrived without a reservation).
// - No combinational path from r_ready_i to way_ready_o or can_issue_o.
// TESTING
// 1 Single beat: grant, then way response {data=64'hA5, id=3, last=1} in cycle 2 -> r_valid_o=1 in cycle 3
//   with the same fields and resp=0; after the R handshake, reserved=0 and can_issue_o=1.
// 2 Credit exhaustion (Depth=4): 4 grants with r_ready_i=0 -> can_issue_o=0 after the 4th grant.
//   4 responses are stored, usage_o=4, way_ready_o=0; one R handshake -> can_issue_o=1 the next cycle.
// 3 Back-pressure: hold r_ready_i=0 for 5 cycles with usage_o=2 -> r_valid_o stays 1 and head fields stay
//   stable; release -> 2 beats in 2 consecutive cycles.
// 4 Simultaneous grant and R handshake with reserved=4 -> reserved stays 4 and can_issue_o stays 0;
//   same for push+pop at usage_o=1 -> usage_o stays 1.
// 5 Wrap/order: stream 11 beats with IDs 0..10, last on beats 3/7/10, random r_ready_i -> R order, IDs and last
//   identical to input; pointers wrap at least twice.
// 6 Reset mid-operation: usage_o=3, reserved=4, then assert rst_ni=0 for 1 cycle -> r_valid_o=0 immediately,
//   usage_o=0 and can_issue_o=1; a fresh single-beat transfer after reset passes.

Source files
------------

// File: rtl/axi_llc_r_resp_buf.sv
// Credit-controlled response buffer between the LLC data-way output mux and the AXI R channel.
// Way responses are stored in a circular FIFO and replayed in order as R beats; credits track reserved slots.
module axi_llc_r_resp_buf #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 6,
    parameter int unsigned Depth     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_grant_i,
    output logic                         can_issue_o,
    input  logic                         way_valid_i,
    output logic                         way_ready_o,
    input  logic [DataWidth-1:0]         way_data_i,
    input  logic [IdWidth-1:0]           way_id_i,
    input  logic                         way_last_i,
    output logic                         r_valid_o,
    input  logic                         r_ready_i,
    output logic [DataWidth-1:0]         r_data_o,
    output logic [IdWidth-1:0]           r_id_o,
    output logic                         r_last_o,
    output logic [1:0]                   r_resp_o,
    output logic [$clog2(Depth+1)-1:0]   usage_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [IdWidth-1:0]   id;
        logic                 last;
    } entry_t;

    entry_t          mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] usage_q, usage_d;
    logic [CntW-1:0] reserved_q, reserved_d;
    logic            push;
    logic            pop;

    // All handshake-side outputs depend on registers only, never on r_ready_i.
    assign way_ready_o = (usage_q < DepthCnt);
    assign can_issue_o = (reserved_q < DepthCnt);
    assign r_valid_o   = (usage_q != '0);
    assign usage_o     = usage_q;
    assign r_resp_o    = 2'b00;

    assign push = way_valid_i & way_ready_o;
    assign pop  = r_valid_o & r_ready_i;

    // Head fields are forced to zero while empty so stale storage never leaks onto R.
    always_comb begin
        r_data_o = '0;
        r_id_o   = '0;
        r_last_o = 1'b0;
        if (r_valid_o) begin
            r_data_o = mem_q[rd_ptr_q].data;
            r_id_o   = mem_q[rd_ptr_q].id;
            r_last_o = mem_q[rd_ptr_q].last;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        usage_d    = usage_q;
        reserved_d = reserved_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   usage_d = usage_q + CntW'(1);
            2'b01:   usage_d = usage_q - CntW'(1);
            default: usage_d = usage_q;
        endcase

        case ({req_grant_i, pop})
            2'b10:   reserved_d = reserved_q + CntW'(1);
            2'b01:   reserved_d = reserved_q - CntW'(1);
            default: reserved_d = reserved_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usage_q    <= '0;
            reserved_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usage_q    <= usage_d;
            reserved_q <= reserved_d;
        end
    end

    // Storage carries no reset; validity is tracked purely by usage_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{data: way_data_i, id: way_id_i, last: way_last_i};
        end
    end

`ifndef SYNTHESIS
    // A grant coinciding with an R handshake leaves the credit count unchanged, so it cannot overflow.
    a_grant_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_grant_i |-> (can_issue_o || pop));
    a_no_way_backpressure: assert property (@(posedge clk_i) disable iff (!rst_ni)
        way_valid_i |-> way_ready_o);
    a_resp_reserved: assert property (@(posedge clk_i) disable iff (!rst_ni)
        way_valid_i |-> (usage_q < reserved_q));
    a_count_order: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (usage_q <= reserved_q) && (reserved_q <= DepthCnt));
    a_r_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_valid_o && !r_ready_i) |=> (r_valid_o && $stable({r_data_o, r_id_o, r_last_o})));
`endif

endmodule

// File: tb/tb_axi_llc_r_resp_buf.sv
// Randomized self-checking bench for axi_llc_r_resp_buf against a queue-based reference model.
module tb_axi_llc_r_resp_buf;

    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] data;
        logic [5:0]  id;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        req_grant;
    logic        can_issue;
    logic        way_valid;
    logic        way_ready;
    logic [63:0] way_data;
    logic [5:0]  way_id;
    logic        way_last;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic [5:0]  r_id;
    logic        r_last;
    logic [1:0]  r_resp;
    logic [2:0]  usage;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];
    beat_t popped_q[$];
    int    model_res = 0;

    axi_llc_r_resp_buf #(.DataWidth(64), .IdWidth(6), .Depth(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_grant_i (req_grant),
        .can_issue_o (can_issue),
        .way_valid_i (way_valid),
        .way_ready_o (way_ready),
        .way_data_i  (way_data),
        .way_id_i    (way_id),
        .way_last_i  (way_last),
        .r_valid_o   (r_valid),
        .r_ready_i   (r_ready),
        .r_data_o    (r_data),
        .r_id_o      (r_id),
        .r_last_o    (r_last),
        .r_resp_o    (r_resp),
        .usage_o     (usage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic g, input logic wv, input logic [63:0] wd,
                         input logic [5:0] wid, input logic wl, input logic rr);
        req_grant = g;
        way_valid = wv;
        way_data  = wd;
        way_id    = wid;
        way_last  = wl;
        r_ready   = rr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 64'd0, 6'd0, 1'b0, 1'b0);
    endtask

    // Advance one clock; the model applies the handshakes implied by the inputs held before the edge.
    task automatic step();
        bit    do_pop;
        bit    do_push;
        int    g;
        beat_t b;
        do_pop  = r_ready && (exp_q.size() > 0);
        do_push = way_valid && (exp_q.size() < DEPTH);
        g       = int'(req_grant);
        b       = '{data: way_data, id: way_id, last: way_last};
        @(posedge clk);
        if (do_pop) begin
            $display("R beat id=%0d data=%h last=%0b", exp_q[0].id, exp_q[0].data, exp_q[0].last);
            popped_q.push_back(exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (do_push) exp_q.push_back(b);
        model_res = model_res + g - int'(do_pop);
        #1;
    endtask

    // Deliver responses for all outstanding reservations and drain the buffer (stimulus only).
    task automatic settle();
        int budget = 0;
        while ((model_res > 0) && (budget < 100)) begin
            if (exp_q.size() < model_res)
                drive(1'b0, 1'b1, {$urandom, $urandom}, 6'($urandom_range(0, 63)), 1'b1, 1'b1);
            else
                drive(1'b0, 1'b0, 64'd0, 6'd0, 1'b0, 1'b1);
            step();
            budget++;
        end
        idle();
        n_checks++;
        if (model_res != 0) begin
            n_fail++;
            $display("FAIL settle_timeout: got reserved=%0d required 0", model_res);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({r_valid, can_issue, way_ready, usage} !== {1'b0, 1'b1, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid=%0b can_issue=%0b way_ready=%0b usage=%0d required 0/1/1/0",
                     r_valid, can_issue, way_ready, usage);
        end
        n_checks++;
        if ({r_data, r_id, r_last, r_resp} !== 73'd0) begin
            n_fail++;
            $display("FAIL reset_fields: got data=%h id=%0d last=%0b resp=%0d required all zero",
                     r_data, r_id, r_last, r_resp);
        end
    endtask

    task automatic test_single_beat();
        drive(1'b1, 1'b0, 64'd0, 6'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 64'hA5, 6'd3, 1'b1, 1'b0);
        n_checks++;
        if (r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_no_fallthrough: got r_valid=%0b required 0", r_valid);
        end
        step();
        idle();
        n_checks++;
        if ({r_valid, r_data, r_id, r_last, r_resp} !== {1'b1, 64'hA5, 6'd3, 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL single_beat: got valid=%0b data=%h id=%0d last=%0b resp=%0d required 1/a5/3/1/0",
                     r_valid, r_data, r_id, r_last, r_resp);
        end
        r_ready = 1'b1;
        step();
        idle();
        n_checks++;
        if ({r_valid, can_issue, usage} !== {1'b0, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL single_after_pop: got valid=%0b can_issue=%0b usage=%0d required 0/1/0",
                     r_valid, can_issue, usage);
        end
    endtask

    task automatic test_credit_exhaustion();
        int budget = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 64'd0, 6'd0, 1'b0, 1'b0);
            step();
            n_checks++;
            if (can_issue !== (model_res < DEPTH)) begin
                n_fail++;
                $display("FAIL credit_grant%0d: got can_issue=%0b required %0b", i, can_issue, model_res < DEPTH);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, {$urandom, $urandom}, 6'(i + 8), 1'($urandom_range(0, 1)), 1'b0);
            step();
        end
        idle();
        n_checks++;
        if ({usage, way_ready, can_issue, r_id} !== {3'd4, 1'b0, 1'b0, exp_q[0].id}) begin
            n_fail++;
            $display("FAIL credit_full: got usage=%0d way_ready=%0b can_issue=%0b head_id=%0d required 4/0/0/%0d",
                     usage, way_ready, can_issue, r_id, exp_q[0].id);
        end
        r_ready = 1'b1;
        step();
        idle();
        n_checks++;
        if ({can_issue, usage} !== {1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL credit_release: got can_issue=%0b usage=%0d required 1/3", can_issue, usage);
        end
        while ((exp_q.size() > 0) && (budget < 20)) begin
            drive(1'b0, 1'b0, 64'd0, 6'd0, 1'b0, 1'b1);
            n_checks++;
            if ({r_valid, r_data, r_id, r_last} !== {1'b1, exp_q[0].data, exp_q[0].id, exp_q[0].last}) begin
                n_fail++;
                $display("FAIL credit_drain: got valid=%0b data=%h id=%0d last=%0b required 1/%h/%0d/%0b",
                         r_valid, r_data, r_id, r_last, exp_q[0].data, exp_q[0].id, exp_q[0].last);
            end
            step();
            budget++;
        end
        idle();
    endtask

    task automatic test_backpressure();
        beat_t pushed[2];
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 64'd0, 6'd0, 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            pushed[i] = '{data: {$urandom, $urandom}, id: 6'($urandom_range(0, 63)), last: 1'(i)};
            drive(1'b0, 1'b1, pushed[i].data, pushed[i].id, pushed[i].last, 1'b0);
            step();
        end
        idle();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({r_valid, r_data, r_id, r_last, usage} !== {1'b1, pushed[0].data, pushed[0].id, pushed[0].last, 3'd2}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%0b data=%h id=%0d usage=%0d required 1/%h/%0d/2",
                         c, r_valid, r_data, r_id, usage, pushed[0].data, pushed[0].id);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            r_ready = 1'b1;
            n_checks++;
            if ({r_valid, r_data, r_id, r_last} !== {1'b1, pushed[i].data, pushed[i].id, pushed[i].last}) begin
                n_fail++;
                $display("FAIL bp_release%0d: got valid=%0b data=%h id=%0d last=%0b required 1/%h/%0d/%0b",
                         i, r_valid, r_data, r_id, r_last, pushed[i].data, pushed[i].id, pushed[i].last);
            end
            step();
        end
        idle();
        n_checks++;
        if ({r_valid, can_issue} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_empty: got valid=%0b can_issue=%0b required 0/1", r_valid, can_issue);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 64'd0, 6'd0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 64'h20, 6'd20, 1'b1, 1'b0);
        step();
        drive(1'b1, 1'b0, 64'd0, 6'd0, 1'b0, 1'b1);
        step();
        idle();
        n_checks++;
        if ({can_issue, usage} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL simul_grant_pop: got can_issue=%0b usage=%0d required 0/0 (reserved model=%0d)",
                     can_issue, usage, model_res);
        end
        drive(1'b0, 1'b1, 64'h21, 6'd21, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 64'h22, 6'd22, 1'b1, 1'b1);
        step();
        idle();
        n_checks++;
        if ({usage, r_valid, r_id, r_data} !== {3'd1, 1'b1, 6'd22, 64'h22}) begin
            n_fail++;
            $display("FAIL simul_push_pop: got usage=%0d valid=%0b id=%0d data=%h required 1/1/22/22",
                     usage, r_valid, r_id, r_data);
        end
        settle();
    endtask

    task automatic test_wrap_order();
        int grants = 0;
        int sent   = 0;
        int cyc    = 0;
        bit g, wv, rr;
        popped_q.delete();
        while ((popped_q.size() < 11) && (cyc < 500)) begin
            g  = (grants < 11) && (model_res < DEPTH) && ($urandom_range(0, 1) == 1);
            wv = (sent < grants) && (exp_q.size() < model_res) && ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) != 0);
            drive(g, wv, {$urandom, 26'd0, 6'(sent)}, 6'(sent),
                  (sent == 3) || (sent == 7) || (sent == 10), rr);
            if (g) grants++;
            if (wv) sent++;
            n_checks++;
            if (r_valid !== (exp_q.size() > 0) || usage !== 3'(exp_q.size())) begin
                n_fail++;
                $display("FAIL wrap_state: got valid=%0b usage=%0d required %0b/%0d",
                         r_valid, usage, exp_q.size() > 0, exp_q.size());
            end else if (r_valid && ({r_data, r_id, r_last} !== {exp_q[0].data, exp_q[0].id, exp_q[0].last})) begin
                n_fail++;
                $display("FAIL wrap_head: got data=%h id=%0d last=%0b required %h/%0d/%0b",
                         r_data, r_id, r_last, exp_q[0].data, exp_q[0].id, exp_q[0].last);
            end
            step();
            cyc++;
        end
        idle();
        n_checks++;
        if (popped_q.size() != 11) begin
            n_fail++;
            $display("FAIL wrap_timeout: got %0d beats required 11", popped_q.size());
        end
        for (int i = 0; i < popped_q.size(); i++) begin
            n_checks++;
            if ((popped_q[i].id != 6'(i)) || (popped_q[i].last != ((i == 3) || (i == 7) || (i == 10)))) begin
                n_fail++;
                $display("FAIL wrap_order%0d: got id=%0d last=%0b required id=%0d", i,
                         popped_q[i].id, popped_q[i].last, i);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 64'd0, 6'd0, 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, {$urandom, $urandom}, 6'(i + 40), 1'b0, 1'b0);
            step();
        end
        idle();
        n_checks++;
        if ({usage, can_issue, r_valid} !== {3'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got usage=%0d can_issue=%0b valid=%0b required 3/0/1",
                     usage, can_issue, r_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({r_valid, usage, can_issue, way_ready, r_id} !== {1'b0, 3'd0, 1'b1, 1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_async: got valid=%0b usage=%0d can_issue=%0b way_ready=%0b id=%0d required 0/0/1/1/0",
                     r_valid, usage, can_issue, way_ready, r_id);
        end
        exp_q.delete();
        model_res = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 64'd0, 6'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 6'd5, 1'b1, 1'b0);
        step();
        idle();
        n_checks++;
        if ({r_valid, r_data, r_id, r_last, usage} !== {1'b1, 64'h1234_5678_9ABC_DEF0, 6'd5, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL rst_mid_fresh: got valid=%0b data=%h id=%0d last=%0b usage=%0d required 1/123456789abcdef0/5/1/1",
                     r_valid, r_data, r_id, r_last, usage);
        end
        r_ready = 1'b1;
        step();
        idle();
        n_checks++;
        if ({r_valid, can_issue, usage} !== {1'b0, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_drain: got valid=%0b can_issue=%0b usage=%0d required 0/1/0",
                     r_valid, can_issue, usage);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_single_beat();
        test_credit_exhaustion();
        test_backpressure();
        test_simultaneous();
        test_wrap_order();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
